mat_operand_server: RTL and testbench

//  Responder/memory side of the mat_mult read/write interface. Holds the two operand

---
 rtl/mat_operand_server_pkg.sv | 20 ++
 rtl/mat_operand_server_if.sv | 35 +++
 rtl/mat_operand_server_bank.sv | 25 ++
 rtl/mat_operand_server.sv | 250 +++++++++++++++++++++++++
 tb/tb_mat_operand_server.sv | 357 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mat_operand_server_pkg.sv
// Shared definitions for the mat_mult operand server: sizing constants and FSM state type.
// Matrix size limits are set here and used by every file in the slice.
package mat_srv_pkg;

   localparam int SPECTRAL_BANDS   = 100;
   localparam int TOTAL_ENDMEMBERS = 20;
   localparam int DIM_W            = $clog2(SPECTRAL_BANDS);
   localparam int BANK_DEPTH       = SPECTRAL_BANDS * TOTAL_ENDMEMBERS;
   localparam int ADDR_W           = $clog2(BANK_DEPTH);

   typedef enum logic [2:0] {
      IDLE,
      LOAD1,
      LOAD2,
      START,
      RUN,
      DRAIN
   } state_t;

endpackage

// File: rtl/mat_operand_server_if.sv
// Read/write bus between mat_mult (master) and the operand server (slave).
interface mat_operand_server_if #(
   parameter int DIM_W   = mat_srv_pkg::DIM_W,
   parameter int T_WIDTH = 32
);

   logic               mat_mult_start;
   logic               rd_addr_valid;
   logic [DIM_W-1:0]   mat1_row;
   logic [DIM_W-1:0]   mat1_col;
   logic [DIM_W-1:0]   mat2_row;
   logic [DIM_W-1:0]   mat2_col;
   logic               mat1_valid;
   logic               mat2_valid;
   logic [T_WIDTH-1:0] mat1;
   logic [T_WIDTH-1:0] mat2;
   logic               out_valid;
   logic [DIM_W-1:0]   out_row;
   logic [DIM_W-1:0]   out_col;
   logic [T_WIDTH-1:0] out;
   logic               mm_done;

   modport master (
      input  mat_mult_start, mat1_valid, mat2_valid, mat1, mat2,
      output rd_addr_valid, mat1_row, mat1_col, mat2_row, mat2_col,
      output out_valid, out_row, out_col, out, mm_done
   );

   modport slave (
      output mat_mult_start, mat1_valid, mat2_valid, mat1, mat2,
      input  rd_addr_valid, mat1_row, mat1_col, mat2_row, mat2_col,
      input  out_valid, out_row, out_col, out, mm_done
   );

endinterface

// File: rtl/mat_operand_server_bank.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
module mat_srv_bank #(
   parameter int DEPTH = mat_srv_pkg::BANK_DEPTH,
   parameter int AW    = mat_srv_pkg::ADDR_W,
   parameter int DW    = 32
) (
   input  logic          clk,
   input  logic          we,
   input  logic [AW-1:0] waddr,
   input  logic [DW-1:0] wdata,
   input  logic          re,
   input  logic [AW-1:0] raddr,
   output logic [DW-1:0] rdata
);

   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we)
         mem[waddr] <= wdata;
      if (re)
         rdata <= mem[raddr];
   end

endmodule

// File: rtl/mat_operand_server.sv
// Operand/result memory server for mat_mult: loads two operand matrices, serves reads,
// captures product writes and streams the product out. OPERAND_REG_EN adds an output register on reads.
module mat_operand_server
   import mat_srv_pkg::*;
#(
   parameter int T_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   input  logic [DIM_W-1:0]     dims_r1,
   input  logic [DIM_W-1:0]     dims_c1,
   input  logic [DIM_W-1:0]     dims_c2,
   input  logic                 ld_valid,
   output logic                 ld_ready,
   input  logic [T_WIDTH-1:0]   ld_data,
   mat_operand_server_if.slave  mm,
   output logic                 res_valid,
   input  logic                 res_ready,
   output logic [T_WIDTH-1:0]   res_data,
   output logic                 res_last,
   output logic                 busy,
   output logic                 err
);

   localparam int PW = 2 * DIM_W + 1;

   function automatic logic [PW-1:0] mul_w(input logic [DIM_W-1:0] a, input logic [DIM_W-1:0] b);
      return PW'(a) * PW'(b);
   endfunction

   function automatic logic [ADDR_W-1:0] lin_addr(input logic [DIM_W-1:0] row,
                                                  input logic [DIM_W-1:0] col,
                                                  input logic [DIM_W-1:0] cols);
      return ADDR_W'(mul_w(row, cols) + PW'(col));
   endfunction

   state_t             state;
   logic [DIM_W-1:0]   r1, c1, c2;
   logic [ADDR_W-1:0]  n1, n2, nr;
   logic [ADDR_W-1:0]  ld_cnt, res_idx;
   logic               start_q, ld_ready_q, busy_q, res_valid_q, err_q;

   logic               dims_ok, ld_fire, ld_last_n1, ld_last_n2;
   logic               oob1, oob2, rd_err, wr_ok, wr_err;
   logic               res_fire, res_at_last;
   logic [ADDR_W-1:0]  rd1_addr, rd2_addr, wr_addr, res_raddr;
   logic [T_WIDTH-1:0] rd1_p1, rd2_p1, rdr_p1;
   logic [T_WIDTH-1:0] mat1_m, mat2_m;
   logic               vld_p1, oob1_p1, oob2_p1;

   // Oversized jobs are refused along with zero dims so that no address can leave a bank.
   assign dims_ok = (dims_r1 != '0) && (dims_c1 != '0) && (dims_c2 != '0) &&
                    (dims_r1 <= DIM_W'(SPECTRAL_BANDS)) &&
                    (dims_c1 <= DIM_W'(SPECTRAL_BANDS)) &&
                    (dims_c2 <= DIM_W'(SPECTRAL_BANDS)) &&
                    (mul_w(dims_r1, dims_c1) <= PW'(BANK_DEPTH)) &&
                    (mul_w(dims_c1, dims_c2) <= PW'(BANK_DEPTH)) &&
                    (mul_w(dims_r1, dims_c2) <= PW'(BANK_DEPTH));

   assign ld_fire    = ld_valid && ld_ready_q;
   assign ld_last_n1 = (ld_cnt == n1 - ADDR_W'(1));
   assign ld_last_n2 = (ld_cnt == n2 - ADDR_W'(1));

   assign oob1   = (mm.mat1_row >= r1) || (mm.mat1_col >= c1);
   assign oob2   = (mm.mat2_row >= c1) || (mm.mat2_col >= c2);
   assign rd_err = mm.rd_addr_valid && (oob1 || oob2);
   assign wr_ok  = mm.out_valid && (state == RUN) && (mm.out_row < r1) && (mm.out_col < c2);
   assign wr_err = mm.out_valid && !wr_ok;

   assign rd1_addr = lin_addr(mm.mat1_row, mm.mat1_col, c1);
   assign rd2_addr = lin_addr(mm.mat2_row, mm.mat2_col, c2);
   assign wr_addr  = lin_addr(mm.out_row, mm.out_col, c2);

   // The drain read address runs one word ahead on a handshake so res_data is ready next cycle.
   assign res_fire    = res_valid_q && res_ready;
   assign res_at_last = (res_idx == nr - ADDR_W'(1));
   assign res_raddr   = res_fire ? res_idx + ADDR_W'(1) : res_idx;

   mat_srv_bank #(.DEPTH(BANK_DEPTH), .AW(ADDR_W), .DW(T_WIDTH)) u_bank1 (
      .clk   (clk),
      .we    ((state == LOAD1) && ld_fire),
      .waddr (ld_cnt),
      .wdata (ld_data),
      .re    (mm.rd_addr_valid),
      .raddr (rd1_addr),
      .rdata (rd1_p1)
   );

   mat_srv_bank #(.DEPTH(BANK_DEPTH), .AW(ADDR_W), .DW(T_WIDTH)) u_bank2 (
      .clk   (clk),
      .we    ((state == LOAD2) && ld_fire),
      .waddr (ld_cnt),
      .wdata (ld_data),
      .re    (mm.rd_addr_valid),
      .raddr (rd2_addr),
      .rdata (rd2_p1)
   );

   mat_srv_bank #(.DEPTH(BANK_DEPTH), .AW(ADDR_W), .DW(T_WIDTH)) u_bank_res (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (wr_addr),
      .wdata (mm.out),
      .re    (state == DRAIN),
      .raddr (res_raddr),
      .rdata (rdr_p1)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         r1          <= '0;
         c1          <= '0;
         c2          <= '0;
         n1          <= '0;
         n2          <= '0;
         nr          <= '0;
         ld_cnt      <= '0;
         res_idx     <= '0;
         start_q     <= 1'b0;
         ld_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         err_q <= err_q || rd_err || wr_err;
         case (state)
            IDLE: begin
               if (go) begin
                  r1     <= dims_r1;
                  c1     <= dims_c1;
                  c2     <= dims_c2;
                  n1     <= ADDR_W'(mul_w(dims_r1, dims_c1));
                  n2     <= ADDR_W'(mul_w(dims_c1, dims_c2));
                  nr     <= ADDR_W'(mul_w(dims_r1, dims_c2));
                  ld_cnt <= '0;
                  err_q  <= !dims_ok || rd_err || wr_err;
                  if (dims_ok) begin
                     state      <= LOAD1;
                     ld_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                  end
               end
            end
            LOAD1: begin
               if (ld_fire) begin
                  if (ld_last_n1) begin
                     ld_cnt <= '0;
                     state  <= LOAD2;
                  end else begin
                     ld_cnt <= ld_cnt + ADDR_W'(1);
                  end
               end
            end
            LOAD2: begin
               if (ld_fire) begin
                  if (ld_last_n2) begin
                     ld_cnt     <= '0;
                     ld_ready_q <= 1'b0;
                     start_q    <= 1'b1;
                     state      <= START;
                  end else begin
                     ld_cnt <= ld_cnt + ADDR_W'(1);
                  end
               end
            end
            START: begin
               start_q <= 1'b0;
               state   <= RUN;
            end
            RUN: begin
               if (mm.mm_done) begin
                  res_idx     <= '0;
                  res_valid_q <= 1'b0;
                  state       <= DRAIN;
               end
            end
            DRAIN: begin
               // First DRAIN cycle only primes the read, so a write landing with mm_done is seen.
               if (!res_valid_q) begin
                  res_valid_q <= 1'b1;
               end else if (res_ready) begin
                  if (res_at_last) begin
                     res_valid_q <= 1'b0;
                     busy_q      <= 1'b0;
                     state       <= IDLE;
                  end else begin
                     res_idx <= res_idx + ADDR_W'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Read stage p1: bank data registered, valid and range flags follow it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p1  <= 1'b0;
         oob1_p1 <= 1'b0;
         oob2_p1 <= 1'b0;
      end else begin
         vld_p1  <= mm.rd_addr_valid;
         oob1_p1 <= oob1;
         oob2_p1 <= oob2;
      end
   end

   assign mat1_m = (vld_p1 && !oob1_p1) ? rd1_p1 : '0;
   assign mat2_m = (vld_p1 && !oob2_p1) ? rd2_p1 : '0;

`ifdef OPERAND_REG_EN
   logic               vld_p2;
   logic [T_WIDTH-1:0] mat1_p2, mat2_p2;

   // Read stage p2: extra output register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         mat1_p2 <= '0;
         mat2_p2 <= '0;
      end else begin
         vld_p2  <= vld_p1;
         mat1_p2 <= mat1_m;
         mat2_p2 <= mat2_m;
      end
   end

   assign mm.mat1_valid = vld_p2;
   assign mm.mat2_valid = vld_p2;
   assign mm.mat1       = mat1_p2;
   assign mm.mat2       = mat2_p2;
`else
   assign mm.mat1_valid = vld_p1;
   assign mm.mat2_valid = vld_p1;
   assign mm.mat1       = mat1_m;
   assign mm.mat2       = mat2_m;
`endif

   assign mm.mat_mult_start = start_q;
   assign ld_ready          = ld_ready_q;
   assign busy              = busy_q;
   assign err               = err_q;
   assign res_valid         = res_valid_q;
   assign res_data          = res_valid_q ? rdr_p1 : '0;
   assign res_last          = res_valid_q && res_at_last;

endmodule

// File: tb/tb_mat_operand_server.sv
// Testbench for mat_operand_server: directed tables, corner sequences and randomized jobs
// checked against a matrix-level reference model.
module tb_mat_operand_server;
   import mat_srv_pkg::*;

   localparam int TW = 32;
`ifdef OPERAND_REG_EN
   localparam int LAT = 2;
`else
   localparam int LAT = 1;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic             go;
   logic [DIM_W-1:0] dims_r1, dims_c1, dims_c2;
   logic             ld_valid, ld_ready;
   logic [TW-1:0]    ld_data;
   logic             res_valid, res_ready, res_last, busy, err;
   logic [TW-1:0]    res_data;

   always #5 clk = ~clk;

   mat_operand_server_if #(.DIM_W(DIM_W), .T_WIDTH(TW)) mm ();

   mat_operand_server #(.T_WIDTH(TW)) dut (
      .clk       (clk),
      .rst       (rst),
      .go        (go),
      .dims_r1   (dims_r1),
      .dims_c1   (dims_c1),
      .dims_c2   (dims_c2),
      .ld_valid  (ld_valid),
      .ld_ready  (ld_ready),
      .ld_data   (ld_data),
      .mm        (mm),
      .res_valid (res_valid),
      .res_ready (res_ready),
      .res_data  (res_data),
      .res_last  (res_last),
      .busy      (busy),
      .err       (err)
   );

   int checks = 0;
   int errors = 0;

   // reference model: the matrices as the server should hold them
   int            R1, C1, C2;
   logic [TW-1:0] A [8][8];
   logic [TW-1:0] B [8][8];
   logic [TW-1:0] P [8][8];
   bit            exp_err;

   typedef struct {
      int            ar, ac, br, bc;
      logic [TW-1:0] e1, e2;
      logic          e_err;
   } rd_vec_t;
   rd_vec_t tv [5];

   task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] expv);
      checks++;
      if (act !== expv) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, expv);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [TW-1:0] m1_at(int r, int c);
      return (r < R1 && c < C1) ? A[r][c] : '0;
   endfunction

   function automatic logic [TW-1:0] m2_at(int r, int c);
      return (r < C1 && c < C2) ? B[r][c] : '0;
   endfunction

   task automatic clear_inputs;
      go = 0; dims_r1 = '0; dims_c1 = '0; dims_c2 = '0;
      ld_valid = 0; ld_data = '0; res_ready = 0;
      mm.rd_addr_valid = 0; mm.mat1_row = '0; mm.mat1_col = '0;
      mm.mat2_row = '0; mm.mat2_col = '0; mm.out_valid = 0;
      mm.out_row = '0; mm.out_col = '0; mm.out = '0; mm.mm_done = 0;
   endtask

   task automatic rand_mats;
      for (int i = 0; i < 8; i++)
         for (int j = 0; j < 8; j++) begin
            A[i][j] = $urandom;
            B[i][j] = $urandom;
         end
      for (int i = 0; i < R1; i++)
         for (int j = 0; j < C2; j++) begin
            P[i][j] = '0;
            for (int k = 0; k < C1; k++)
               P[i][j] = P[i][j] + A[i][k] * B[k][j];
         end
   endtask

   task automatic start_job(int r1, int c1, int c2);
      R1 = r1; C1 = c1; C2 = c2;
      dims_r1 = DIM_W'(r1); dims_c1 = DIM_W'(c1); dims_c2 = DIM_W'(c2);
      go = 1;
      tick;
      go = 0;
      exp_err = (r1 == 0 || c1 == 0 || c2 == 0);
   endtask

   task automatic load_all(bit gaps);
      logic [TW-1:0] words [$];
      int not_ready = 0;
      for (int i = 0; i < R1; i++) for (int j = 0; j < C1; j++) words.push_back(A[i][j]);
      for (int i = 0; i < C1; i++) for (int j = 0; j < C2; j++) words.push_back(B[i][j]);
      foreach (words[k]) begin
         if (gaps && $urandom_range(0, 2) == 0) begin
            ld_valid = 0;
            tick;
         end
         ld_valid = 1;
         ld_data  = words[k];
         if (!ld_ready) not_ready++;
         tick;
      end
      ld_valid = 0;
      chk("ld_ready during load", not_ready, 0);
      chk("start pulse", mm.mat_mult_start, 1);
      chk("ld_ready after load", ld_ready, 0);
      tick;
      chk("start pulse width", mm.mat_mult_start, 0);
      chk("busy in run", busy, 1);
   endtask

   task automatic do_read(int ar, int ac, int br, int bc, logic [TW-1:0] e1, logic [TW-1:0] e2,
                          logic e_err, string tag);
      mm.rd_addr_valid = 1;
      mm.mat1_row = DIM_W'(ar); mm.mat1_col = DIM_W'(ac);
      mm.mat2_row = DIM_W'(br); mm.mat2_col = DIM_W'(bc);
      tick;
      mm.rd_addr_valid = 0;
      if (LAT == 2) begin
         chk({tag, " early valid"}, mm.mat1_valid, 0);
         tick;
      end
      chk({tag, " mat1_valid"}, mm.mat1_valid, 1);
      chk({tag, " mat2_valid"}, mm.mat2_valid, 1);
      chk({tag, " mat1"}, mm.mat1, e1);
      chk({tag, " mat2"}, mm.mat2, e2);
      chk({tag, " err"}, err, e_err);
      tick;
   endtask

   task automatic burst_reads(int n);
      logic [TW-1:0] q1 [$];
      logic [TW-1:0] q2 [$];
      int ar, ac, br, bc;
      for (int t = 0; t < n + LAT; t++) begin
         if (t < n) begin
            ar = $urandom_range(0, R1); ac = $urandom_range(0, C1 - 1);
            br = $urandom_range(0, C1 - 1); bc = $urandom_range(0, C2);
            mm.rd_addr_valid = 1;
            mm.mat1_row = DIM_W'(ar); mm.mat1_col = DIM_W'(ac);
            mm.mat2_row = DIM_W'(br); mm.mat2_col = DIM_W'(bc);
            q1.push_back(m1_at(ar, ac));
            q2.push_back(m2_at(br, bc));
            if (ar >= R1 || bc >= C2) exp_err = 1;
         end else begin
            mm.rd_addr_valid = 0;
         end
         tick;
         if (t >= LAT - 1 && q1.size() > 0) begin
            chk("burst valid", mm.mat1_valid, 1);
            chk("burst mat1", mm.mat1, q1.pop_front());
            chk("burst mat2", mm.mat2, q2.pop_front());
         end
      end
      mm.rd_addr_valid = 0;
   endtask

   task automatic write_product(bit shuffle, bit bad_final);
      int pi [$];
      int pj [$];
      int n, s, tmp;
      for (int i = 0; i < R1; i++) for (int j = 0; j < C2; j++) begin
         pi.push_back(i); pj.push_back(j);
      end
      n = pi.size();
      if (shuffle)
         for (int k = n - 1; k > 0; k--) begin
            s = $urandom_range(0, k);
            tmp = pi[k]; pi[k] = pi[s]; pi[s] = tmp;
            tmp = pj[k]; pj[k] = pj[s]; pj[s] = tmp;
         end
      for (int k = 0; k < n; k++) begin
         mm.out_valid = 1;
         mm.out_row = DIM_W'(pi[k]); mm.out_col = DIM_W'(pj[k]); mm.out = P[pi[k]][pj[k]];
         mm.mm_done = !bad_final && (k == n - 1);
         tick;
      end
      if (bad_final) begin
         // col == C2 aliases onto row 1 if the write were not dropped
         mm.out_valid = 1; mm.out_row = '0; mm.out_col = DIM_W'(C2); mm.out = 32'hDEAD_BEEF;
         mm.mm_done = 1;
         exp_err = 1;
         tick;
      end
      mm.out_valid = 0; mm.mm_done = 0;
      chk("err after writes", err, exp_err);
   endtask

   task automatic drain(int mode);
      int n = R1 * C2;
      int k = 0;
      int cyc = 0;
      bit pend = 0;
      bit tog = 1;
      bit rdy;
      logic [TW-1:0] held = '0;
      while (k < n && cyc < 500) begin
         rdy = (mode == 0) ? 1'b1 : (mode == 1) ? tog : 1'($urandom_range(0, 1));
         tog = ~tog;
         res_ready = rdy;
         if (res_valid) begin
            if (pend) chk("res hold", res_data, held);
            if (rdy) begin
               chk("res word", res_data, P[k / C2][k % C2]);
               chk("res_last", res_last, (k == n - 1));
               k++;
               pend = 0;
            end else begin
               pend = 1;
               held = res_data;
            end
         end
         tick;
         cyc++;
      end
      res_ready = 0;
      chk("drain word count", k, n);
      chk("busy after drain", busy, 0);
      chk("res_valid after drain", res_valid, 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      clear_inputs();
      rst = 1;
      repeat (2) tick;
      rst = 0;
      tick;

      chk("reset busy", busy, 0);
      chk("reset ld_ready", ld_ready, 0);
      chk("reset err", err, 0);
      chk("reset res_valid", res_valid, 0);
      chk("reset res_last", res_last, 0);
      chk("reset start", mm.mat_mult_start, 0);
      chk("reset mat1_valid", mm.mat1_valid, 0);

      // Job 1: dims 2/3/2, operands 1..6 and 7..12
      start_job(2, 3, 2);
      chk("job1 busy", busy, 1);
      chk("job1 ld_ready", ld_ready, 1);
      chk("job1 err", err, 0);
      for (int i = 0; i < 2; i++) for (int j = 0; j < 3; j++) A[i][j] = 32'(i * 3 + j + 1);
      for (int i = 0; i < 3; i++) for (int j = 0; j < 2; j++) B[i][j] = 32'(7 + i * 2 + j);
      P[0][0] = 58; P[0][1] = 64; P[1][0] = 139; P[1][1] = 154;
      load_all(0);
      tv[0] = '{ar:1, ac:2, br:2, bc:1, e1:6, e2:12, e_err:0};
      tv[1] = '{ar:0, ac:0, br:0, bc:0, e1:1, e2:7,  e_err:0};
      tv[2] = '{ar:0, ac:2, br:1, bc:1, e1:3, e2:10, e_err:0};
      tv[3] = '{ar:1, ac:0, br:2, bc:0, e1:4, e2:11, e_err:0};
      tv[4] = '{ar:5, ac:0, br:0, bc:1, e1:0, e2:8,  e_err:1};
      foreach (tv[i]) do_read(tv[i].ar, tv[i].ac, tv[i].br, tv[i].bc, tv[i].e1, tv[i].e2,
                              tv[i].e_err, $sformatf("tbl%0d", i));
      exp_err = 1;
      write_product(0, 0);
      drain(0);

      // Job 2: go clears err, go while busy ignored, gapped load, toggling res_ready
      start_job(2, 3, 2);
      chk("go clears err", err, 0);
      rand_mats();
      dims_c2 = '0; go = 1;
      tick;
      go = 0;
      chk("go ignored err", err, 0);
      chk("go ignored busy", busy, 1);
      chk("go ignored ld_ready", ld_ready, 1);
      load_all(1);
      write_product(1, 0);
      drain(1);

      // Zero dimension
      start_job(2, 3, 0);
      chk("zero dim err", err, 1);
      chk("zero dim busy", busy, 0);
      chk("zero dim ld_ready", ld_ready, 0);
      tick;
      chk("zero dim stays idle", busy, 0);

      // Write during LOAD1, then reset mid-RUN
      start_job(2, 2, 2);
      chk("err cleared", err, 0);
      rand_mats();
      mm.out_valid = 1; mm.out_row = '0; mm.out_col = '0; mm.out = 32'd99;
      tick;
      mm.out_valid = 0;
      chk("write in LOAD1 err", err, 1);
      chk("write in LOAD1 ld_ready", ld_ready, 1);
      load_all(0);
      A[1][1] = A[1][1] | 32'h1;
      mm.rd_addr_valid = 1;
      mm.mat1_row = 1; mm.mat1_col = 0; mm.mat2_row = 1; mm.mat2_col = 1;
      tick;
      mm.rd_addr_valid = 0;
      if (LAT == 2) tick;
      chk("pre-reset mat1_valid", mm.mat1_valid, 1);
      chk("pre-reset mat1", mm.mat1, A[1][0]);
      #2 rst = 1;
      #1;
      chk("async rst busy", busy, 0);
      chk("async rst err", err, 0);
      chk("async rst mat1_valid", mm.mat1_valid, 0);
      chk("async rst mat1", mm.mat1, 0);
      chk("async rst mat2", mm.mat2, 0);
      chk("async rst ld_ready", ld_ready, 0);
      chk("async rst res_valid", res_valid, 0);
      #2 rst = 0;
      tick;

      // Randomized jobs against the model
      for (int j = 0; j < 6; j++) begin
         start_job($urandom_range(1, 5), $urandom_range(1, 5), $urandom_range(1, 5));
         chk("rand job busy", busy, 1);
         rand_mats();
         load_all(1);
         burst_reads(8);
         chk("rand job read err", err, exp_err);
         write_product(1, (R1 > 1) && ($urandom_range(0, 1) == 1));
         drain(2);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
